// File: rtl/tt_check_pkg.sv
// Shared types and latency helper for the truth-table sweep checker.
package tt_check_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Compare latency L: the ROM needs one cycle even when the implementations are combinational.
  function automatic int unsigned align_lat(input int unsigned dut_lat);
    return (dut_lat > 0) ? dut_lat : 1;
  endfunction

endpackage

// File: rtl/tt_delay_line.sv
// Fixed-depth shift register used to align ROM data, implementation outputs and the issue tag.
module tt_delay_line #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_wire
    logic unused_ok;
    assign unused_ok = ^{clk, rst_n, clr};
    assign q = d;
  end else begin : g_pipe
    localparam int unsigned PIPE_W = DEPTH * WIDTH;
    logic [PIPE_W-1:0] pipe_q, pipe_d;

    // Newest sample enters the low slot; the top slot falls off.
    always_comb begin
      pipe_d = PIPE_W'({pipe_q, d});
      if (clr) pipe_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pipe_q <= '0;
      else        pipe_q <= pipe_d;
    end

    assign q = pipe_q[PIPE_W-1 -: WIDTH];
  end

endmodule

// File: rtl/tt_sweep_checker.sv
// Sweeps every input vector, compares NUM_IMPL implementations against an external ROM
// and reports error statistics.
module tt_sweep_checker
  import tt_check_pkg::*;
#(
  parameter int unsigned IN_W        = 13,
  parameter int unsigned OUT_W       = 8,
  parameter int unsigned NUM_IMPL    = 2,
  parameter int unsigned DUT_LAT     = 0,
  parameter int unsigned STOP_ON_ERR = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      abort,
  output logic [IN_W-1:0]           stim,
  output logic [IN_W-1:0]           table_addr,
  input  logic [OUT_W-1:0]          table_data,
  input  logic [NUM_IMPL*OUT_W-1:0] dut_y,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic                      err_pulse,
  output logic [IN_W:0]             err_count,
  output logic [IN_W-1:0]           first_err_addr,
  output logic [NUM_IMPL-1:0]       first_err_mask
);

  localparam int unsigned L     = align_lat(DUT_LAT);
  localparam int unsigned Y_W   = NUM_IMPL * OUT_W;
  localparam int unsigned CNT_W = IN_W + 1;

  state_e              state_q, state_d;
  logic [IN_W-1:0]     idx_q, idx_d;
  logic [CNT_W-1:0]    err_count_q, err_count_d;
  logic [IN_W-1:0]     first_err_addr_q, first_err_addr_d;
  logic [NUM_IMPL-1:0] first_err_mask_q, first_err_mask_d;
  logic                first_seen_q, first_seen_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;

  logic                clr_pipe_c;
  logic [OUT_W-1:0]    exp_al;
  logic [Y_W-1:0]      dut_al;
  logic [IN_W:0]       tag_al;
  logic                cmp_vld;
  logic [IN_W-1:0]     cmp_idx;
  logic [NUM_IMPL-1:0] mism_c;
  logic                hit_c, running_c, cmp_en_c;

  tt_delay_line #(.WIDTH(OUT_W), .DEPTH(L - 1)) u_dly_table (
    .clk(clk), .rst_n(rst_n), .clr(clr_pipe_c), .d(table_data), .q(exp_al)
  );

  tt_delay_line #(.WIDTH(Y_W), .DEPTH(L - DUT_LAT)) u_dly_dut (
    .clk(clk), .rst_n(rst_n), .clr(clr_pipe_c), .d(dut_y), .q(dut_al)
  );

  // Index travels with a valid bit so only vectors issued in RUN are ever compared.
  tt_delay_line #(.WIDTH(IN_W + 1), .DEPTH(L)) u_dly_idx (
    .clk(clk), .rst_n(rst_n), .clr(clr_pipe_c),
    .d({state_q == ST_RUN, idx_q}), .q(tag_al)
  );

  assign cmp_vld = tag_al[IN_W];
  assign cmp_idx = tag_al[IN_W-1:0];

  for (genvar g = 0; g < NUM_IMPL; g++) begin : g_cmp
    assign mism_c[g] = (dut_al[g*OUT_W +: OUT_W] != exp_al);
  end

  assign hit_c     = |mism_c;
  assign running_c = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign cmp_en_c  = cmp_vld && running_c && !abort;

  always_comb begin
    state_d          = state_q;
    idx_d            = idx_q;
    err_count_d      = err_count_q;
    first_err_addr_d = first_err_addr_q;
    first_err_mask_d = first_err_mask_q;
    first_seen_d     = first_seen_q;
    pass_d           = pass_q;
    clr_pipe_c       = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d          = ST_RUN;
          idx_d            = '0;
          err_count_d      = '0;
          first_err_addr_d = '0;
          first_err_mask_d = '0;
          first_seen_d     = 1'b0;
          pass_d           = 1'b0;
          clr_pipe_c       = 1'b1;
        end
      end
      ST_RUN:   if (idx_q == '1) state_d = ST_DRAIN;
      ST_DRAIN: if (cmp_en_c && cmp_idx == '1) state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase

    if (cmp_en_c && hit_c) begin
      err_count_d = err_count_q + CNT_W'(1);
      if (!first_seen_q) begin
        first_seen_d     = 1'b1;
        first_err_addr_d = cmp_idx;
        first_err_mask_d = mism_c;
      end
      if (STOP_ON_ERR != 0) state_d = ST_DONE;
    end

    if (running_c && abort) state_d = ST_IDLE;

    // Advance only while staying in RUN so stim holds its last issued value otherwise.
    if (state_q == ST_RUN && state_d == ST_RUN) idx_d = idx_q + IN_W'(1);

    if (state_d == ST_DONE && state_q != ST_DONE) pass_d = (err_count_d == '0);

    busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_IDLE;
      idx_q            <= '0;
      err_count_q      <= '0;
      first_err_addr_q <= '0;
      first_err_mask_q <= '0;
      first_seen_q     <= 1'b0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      pass_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      idx_q            <= idx_d;
      err_count_q      <= err_count_d;
      first_err_addr_q <= first_err_addr_d;
      first_err_mask_q <= first_err_mask_d;
      first_seen_q     <= first_seen_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      pass_q           <= pass_d;
    end
  end

  assign stim           = idx_q;
  assign table_addr     = idx_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_pulse      = cmp_en_c && hit_c;
  assign err_count      = err_count_q;
  assign first_err_addr = first_err_addr_q;
  assign first_err_mask = first_err_mask_q;

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Scoreboard bench: three checker instances (combinational, 3-cycle latency, stop-on-error).
module tb_tt_sweep_checker;

  localparam int unsigned IN_W  = 4;
  localparam int unsigned OUT_W = 8;
  localparam int unsigned NI    = 2;

  typedef struct {
    int   done_k;
    logic pass;
    int   cnt;
    int   addr;
    int   mask;
  } res_t;

  logic clk, rst_n;
  logic start_a, start_b, start_c;
  logic abort_a, abort_n;

  logic [IN_W-1:0] stim_a, stim_b, stim_c, ta_a, ta_b, ta_c;
  logic [OUT_W-1:0] td_a, td_b, td_c;
  logic [NI*OUT_W-1:0] y_a, y_b_raw, y_b1, y_b2, y_b3, y_c;
  logic busy_a, busy_b, busy_c, done_a, done_b, done_c, pass_a, pass_b, pass_c;
  logic err_a, err_b, err_c;
  logic [IN_W:0] cnt_a, cnt_b, cnt_c;
  logic [IN_W-1:0] fa_a, fa_b, fa_c;
  logic [NI-1:0] fm_a, fm_b, fm_c;

  logic [1:0] flt_a [16];
  logic [1:0] flt_b [16];
  logic [1:0] flt_c [16];

  int checks = 0;
  int failures = 0;
  res_t res_q[$];
  int pulse_q[$];

  function automatic logic [OUT_W-1:0] rom(input logic [IN_W-1:0] a);
    return OUT_W'({4'd0, a} * 8'd37 + 8'd5);
  endfunction

  function automatic res_t mk_res(input int k, input logic p, input int c, input int ad, input int m);
    res_t r;
    r.done_k = k; r.pass = p; r.cnt = c; r.addr = ad; r.mask = m;
    return r;
  endfunction

  // Reference ROM (1-cycle read) and implementations with optional bit-0 faults.
  always @(posedge clk) begin
    td_a <= rom(ta_a);
    td_b <= rom(ta_b);
    td_c <= rom(ta_c);
    y_b1 <= y_b_raw;
    y_b2 <= y_b1;
    y_b3 <= y_b2;
  end

  assign y_a     = {rom(stim_a) ^ {7'd0, flt_a[stim_a][1]}, rom(stim_a) ^ {7'd0, flt_a[stim_a][0]}};
  assign y_b_raw = {rom(stim_b) ^ {7'd0, flt_b[stim_b][1]}, rom(stim_b) ^ {7'd0, flt_b[stim_b][0]}};
  assign y_c     = {rom(stim_c) ^ {7'd0, flt_c[stim_c][1]}, rom(stim_c) ^ {7'd0, flt_c[stim_c][0]}};

  tt_sweep_checker #(.IN_W(IN_W), .OUT_W(OUT_W), .NUM_IMPL(NI), .DUT_LAT(0), .STOP_ON_ERR(0)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .stim(stim_a), .table_addr(ta_a),
    .table_data(td_a), .dut_y(y_a), .busy(busy_a), .done(done_a), .pass(pass_a), .err_pulse(err_a),
    .err_count(cnt_a), .first_err_addr(fa_a), .first_err_mask(fm_a)
  );

  tt_sweep_checker #(.IN_W(IN_W), .OUT_W(OUT_W), .NUM_IMPL(NI), .DUT_LAT(3), .STOP_ON_ERR(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_n), .stim(stim_b), .table_addr(ta_b),
    .table_data(td_b), .dut_y(y_b3), .busy(busy_b), .done(done_b), .pass(pass_b), .err_pulse(err_b),
    .err_count(cnt_b), .first_err_addr(fa_b), .first_err_mask(fm_b)
  );

  tt_sweep_checker #(.IN_W(IN_W), .OUT_W(OUT_W), .NUM_IMPL(NI), .DUT_LAT(0), .STOP_ON_ERR(1)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .abort(abort_n), .stim(stim_c), .table_addr(ta_c),
    .table_data(td_c), .dut_y(y_c), .busy(busy_c), .done(done_c), .pass(pass_c), .err_pulse(err_c),
    .err_count(cnt_c), .first_err_addr(fa_c), .first_err_mask(fm_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic set_start(input int sel, input logic v);
    case (sel)
      0:       start_a = v;
      1:       start_b = v;
      default: start_c = v;
    endcase
  endtask

  task automatic sample(input int sel, output logic e, output logic d, output logic p,
                        output int cnt, output int addr, output int mask);
    case (sel)
      0:       begin e = err_a; d = done_a; p = pass_a; cnt = int'(cnt_a); addr = int'(fa_a); mask = int'(fm_a); end
      1:       begin e = err_b; d = done_b; p = pass_b; cnt = int'(cnt_b); addr = int'(fa_b); mask = int'(fm_b); end
      default: begin e = err_c; d = done_c; p = pass_c; cnt = int'(cnt_c); addr = int'(fa_c); mask = int'(fm_c); end
    endcase
  endtask

  // Start a sweep, then watch up to last_k cycles; cycle k is sampled on the negedge after
  // the k-th rising edge following the edge that accepted start.
  task automatic run_sweep(input int sel, input int poke_k, input int last_k, output bit found);
    logic e, d, p;
    int cnt, addr, mask;
    res_t r;
    found = 1'b0;
    @(negedge clk);
    set_start(sel, 1'b1);
    @(negedge clk);
    set_start(sel, 1'b0);
    for (int k = 1; k <= last_k; k++) begin
      @(negedge clk);
      set_start(sel, 1'b0);
      sample(sel, e, d, p, cnt, addr, mask);
      if (e) begin
        if (pulse_q.size() == 0) check_eq("pulse_unexpected", 32'(e), 0);
        else                     check_eq("pulse_cycle", k, pulse_q.pop_front());
      end
      if (d) begin
        r = res_q.pop_front();
        check_eq("done_cycle", k, r.done_k);
        check_eq("pass", 32'(p), 32'(r.pass));
        check_eq("err_count", cnt, r.cnt);
        check_eq("first_err_addr", addr, r.addr);
        check_eq("first_err_mask", mask, r.mask);
        found = 1'b1;
        break;
      end
      if (k == poke_k) set_start(sel, 1'b1);
    end
    check_eq("pulses_left", pulse_q.size(), 0);
  endtask

  initial begin
    bit found;
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    abort_a = 1'b0; abort_n = 1'b0;
    for (int i = 0; i < 16; i++) begin flt_a[i] = 2'b00; flt_b[i] = 2'b00; flt_c[i] = 2'b00; end
    repeat (3) @(negedge clk);

    check_eq("rst_busy", 32'(busy_a), 0);
    check_eq("rst_done", 32'(done_a), 0);
    check_eq("rst_pass", 32'(pass_a), 0);
    check_eq("rst_err_pulse", 32'(err_a), 0);
    check_eq("rst_stim", 32'(stim_a), 0);
    check_eq("rst_err_count", 32'(cnt_a), 0);
    rst_n = 1'b1;

    // Clean sweep; a second start mid-sweep must be ignored.
    res_q.push_back(mk_res(17, 1'b1, 0, 0, 0));
    run_sweep(0, 5, 40, found);
    check_eq("clean_found", 32'(found), 1);
    check_eq("stim_hold_end", 32'(stim_a), 15);

    // Implementation 1 faulty at 5 and 9, restarted from DONE.
    flt_a[5] = 2'b10; flt_a[9] = 2'b10;
    pulse_q.push_back(6); pulse_q.push_back(10);
    res_q.push_back(mk_res(17, 1'b0, 2, 5, 2));
    run_sweep(0, -1, 40, found);
    check_eq("two_fault_found", 32'(found), 1);

    // Three-cycle implementation latency, fault at the last vector.
    flt_b[15] = 2'b01;
    pulse_q.push_back(18);
    res_q.push_back(mk_res(19, 1'b0, 1, 15, 1));
    run_sweep(1, -1, 40, found);
    check_eq("lat3_found", 32'(found), 1);

    // Stop on first error; the fault at index 3 is in flight and must be discarded.
    flt_c[2] = 2'b11; flt_c[3] = 2'b01;
    pulse_q.push_back(3);
    res_q.push_back(mk_res(4, 1'b0, 1, 2, 3));
    run_sweep(2, -1, 40, found);
    check_eq("stop_found", 32'(found), 1);

    // Abort while index 7 is issued.
    flt_a[9] = 2'b00;
    pulse_q.push_back(6);
    run_sweep(0, -1, 7, found);
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    check_eq("abort_busy", 32'(busy_a), 0);
    check_eq("abort_done", 32'(done_a), 0);
    check_eq("abort_stim", 32'(stim_a), 7);
    check_eq("abort_err_count", 32'(cnt_a), 1);
    check_eq("abort_first_addr", 32'(fa_a), 5);
    repeat (3) @(negedge clk);
    check_eq("abort_stays_idle", 32'(busy_a), 0);
    flt_a[5] = 2'b00;
    res_q.push_back(mk_res(17, 1'b1, 0, 0, 0));
    run_sweep(0, -1, 40, found);
    check_eq("post_abort_found", 32'(found), 1);

    // Asynchronous reset mid-sweep, checked before the next clock edge.
    flt_a[2] = 2'b01;
    pulse_q.push_back(3);
    run_sweep(0, -1, 6, found);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_busy", 32'(busy_a), 0);
    check_eq("arst_stim", 32'(stim_a), 0);
    check_eq("arst_err_count", 32'(cnt_a), 0);
    check_eq("arst_first_addr", 32'(fa_a), 0);
    check_eq("arst_first_mask", 32'(fm_a), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check_eq("arst_no_activity_busy", 32'(busy_a), 0);
    check_eq("arst_no_activity_done", 32'(done_a), 0);
    check_eq("arst_no_activity_stim", 32'(stim_a), 0);
    check_eq("results_left", res_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
